regfile_8x8_onehot: RTL and testbench

//  8-entry x WIDTH register bank written through a one-hot row select from the
//  3-to-8 line decoder. The decoder drives wsel; this block stores the data.
//  Two asynchronous read ports are addressed by binary 3-bit addresses.

---
 rtl/regfile_8x8_onehot.sv | 132 +++++++++++++
 tb/tb_regfile_8x8_onehot.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_8x8_onehot.sv
// ---------------------------------------------------------------------------
// regfile_8x8_onehot
//
// Eight-entry register bank, WIDTH bits per entry. Rows are written
// through a one-hot select (wsel) supplied by an external 3-to-8 line
// decoder. Each row carries a valid bit. Two read ports, addressed in
// binary, return data and valid bits with zero latency.
//
// A write request whose select is not exactly one-hot is rejected. No
// row changes, and a sticky error flag is raised that only reset clears.
// Accepted writes are counted in a 4-bit counter that saturates at 15.
//
// Optional build macro:
//   REGFILE_BYPASS_EN  When defined, an accepted write is forwarded
//                      combinationally to any read port that addresses
//                      the row being written in the same cycle.
//                      When undefined, the read ports show the stored
//                      value until after the clock edge.
//                      Rejected writes are never forwarded in either build.
//
// Parameters:
//   WIDTH     data width per entry (1..32)
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous, active-high reset
//   we        write request
//   wsel      one-hot row select (bit n selects entry n)
//   wdata     write data
//   raddr_a   read port A address
//   raddr_b   read port B address
//   rdata_a   entry[raddr_a]
//   rdata_b   entry[raddr_b]
//   rvalid_a  valid[raddr_a]
//   rvalid_b  valid[raddr_b]
//   sel_err   sticky flag for a write request with a non-one-hot select
//   wcount    count of accepted writes, saturating at 15
// ---------------------------------------------------------------------------
module regfile_8x8_onehot #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [7:0]       wsel,
  input  logic [WIDTH-1:0] wdata,
  input  logic [2:0]       raddr_a,
  input  logic [2:0]       raddr_b,
  output logic [WIDTH-1:0] rdata_a,
  output logic [WIDTH-1:0] rdata_b,
  output logic             rvalid_a,
  output logic             rvalid_b,
  output logic             sel_err,
  output logic [3:0]       wcount
);

  logic [WIDTH-1:0] entry [8];
  logic [7:0]       valid;

  logic sel_onehot;
  logic wr_accept;
  logic wr_reject;

  // Clearing the lowest set bit leaves zero only when at most one bit was
  // set. The non-zero test removes the empty-select case.
  // A write coinciding with reset is treated as never having happened.
  // That matters for the forwarding path, because reset is synchronous.
  always_comb begin
    sel_onehot = (wsel != 8'd0) && ((wsel & (wsel - 8'd1)) == 8'd0);
    wr_accept  = we && sel_onehot && !rst;
    wr_reject  = we && !sel_onehot;
  end

  // Row storage and valid bits. Because wsel is one-hot, at most one row
  // matches on an accepted write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        entry[i] <= '0;
      end
      valid <= 8'd0;
    end else if (wr_accept) begin
      for (int i = 0; i < 8; i++) begin
        if (wsel[i]) begin
          entry[i] <= wdata;
          valid[i] <= 1'b1;
        end
      end
    end
  end

  // Sticky select-error flag. It is set only by a write request, because
  // wsel is meaningless when we is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_err <= 1'b0;
    end else if (wr_reject) begin
      sel_err <= 1'b1;
    end
  end

  // Count of accepted writes. The counter holds at 15 instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wcount <= 4'd0;
    end else if (wr_accept && (wcount != 4'hF)) begin
      wcount <= wcount + 4'd1;
    end
  end

  // Read ports. The stored value is always available. The forwarding build
  // overrides it with the incoming data when the addressed row is the one
  // being written this cycle.
  always_comb begin
    rdata_a  = entry[raddr_a];
    rvalid_a = valid[raddr_a];
    rdata_b  = entry[raddr_b];
    rvalid_b = valid[raddr_b];
`ifdef REGFILE_BYPASS_EN
    if (wr_accept && wsel[raddr_a]) begin
      rdata_a  = wdata;
      rvalid_a = 1'b1;
    end
    if (wr_accept && wsel[raddr_b]) begin
      rdata_b  = wdata;
      rvalid_b = 1'b1;
    end
`else
`endif
  end

endmodule

// File: tb/tb_regfile_8x8_onehot.sv
// ---------------------------------------------------------------------------
// tb_regfile_8x8_onehot
//
// Self-checking bench for regfile_8x8_onehot with WIDTH = 8.
// A reference model holds the bank as plain arrays. The model accepts a
// write when the select has exactly one bit set, counted with $countones.
// Directed scenarios run first, followed by a randomized phase.
// Define REGFILE_BYPASS_EN for both this bench and the RTL to exercise the
// forwarding build.
// ---------------------------------------------------------------------------
module tb_regfile_8x8_onehot;

  logic       clk;
  logic       rst;
  logic       we;
  logic [7:0] wsel;
  logic [7:0] wdata;
  logic [2:0] raddr_a;
  logic [2:0] raddr_b;
  logic [7:0] rdata_a;
  logic [7:0] rdata_b;
  logic       rvalid_a;
  logic       rvalid_b;
  logic       sel_err;
  logic [3:0] wcount;

  int checks;
  int failures;

  // Reference model state
  logic [7:0] m_mem [8];
  logic       m_valid [8];
  logic       m_err;
  int         m_cnt;

  logic [7:0] last_data [8];

  regfile_8x8_onehot #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .we       (we),
    .wsel     (wsel),
    .wdata    (wdata),
    .raddr_a  (raddr_a),
    .raddr_b  (raddr_b),
    .rdata_a  (rdata_a),
    .rdata_b  (rdata_b),
    .rvalid_a (rvalid_a),
    .rvalid_b (rvalid_b),
    .sel_err  (sel_err),
    .wcount   (wcount)
  );

  // Free-running clock with a 10-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic bit fwd_hit(input logic [2:0] addr);
`ifdef REGFILE_BYPASS_EN
    return (!rst && we && ($countones(wsel) == 1) && wsel[addr]);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [7:0] exp_data(input logic [2:0] addr);
    if (fwd_hit(addr)) return wdata;
    return m_mem[addr];
  endfunction

  function automatic logic exp_valid(input logic [2:0] addr);
    if (fwd_hit(addr)) return 1'b1;
    return m_valid[addr];
  endfunction

  // Model update for one clock edge, using the inputs present before it.
  task automatic modelEdge();
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        m_mem[i]   = 8'd0;
        m_valid[i] = 1'b0;
      end
      m_err = 1'b0;
      m_cnt = 0;
    end else if (we) begin
      if ($countones(wsel) == 1) begin
        for (int i = 0; i < 8; i++) begin
          if (wsel[i]) begin
            m_mem[i]   = wdata;
            m_valid[i] = 1'b1;
          end
        end
        if (m_cnt < 15) m_cnt = m_cnt + 1;
      end else begin
        m_err = 1'b1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  task automatic applyStimulus(input logic r, input logic w, input logic [7:0] sel,
                               input logic [7:0] data, input logic [2:0] ra,
                               input logic [2:0] rb);
    rst     = r;
    we      = w;
    wsel    = sel;
    wdata   = data;
    raddr_a = ra;
    raddr_b = rb;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, "_rdata_a"},  {24'd0, rdata_a}, {24'd0, exp_data(raddr_a)});
    checkOutput({tag, "_rdata_b"},  {24'd0, rdata_b}, {24'd0, exp_data(raddr_b)});
    checkOutput({tag, "_rvalid_a"}, {31'd0, rvalid_a}, {31'd0, exp_valid(raddr_a)});
    checkOutput({tag, "_rvalid_b"}, {31'd0, rvalid_b}, {31'd0, exp_valid(raddr_b)});
    checkOutput({tag, "_sel_err"},  {31'd0, sel_err}, {31'd0, m_err});
    checkOutput({tag, "_wcount"},   {28'd0, wcount}, m_cnt);
  endtask

  // Directed scenarios followed by randomized traffic.
  initial begin
    logic [7:0] rsel;
    logic       rrst;
    checks   = 0;
    failures = 0;
    m_err    = 1'b0;
    m_cnt    = 0;
    for (int i = 0; i < 8; i++) begin
      m_mem[i]   = 8'd0;
      m_valid[i] = 1'b0;
    end

    // Reset.
    applyStimulus(1'b1, 1'b0, 8'h00, 8'h00, 3'd0, 3'd7);
    tick();
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 3'd7);
    checkOutput("rst_rdata_a",  {24'd0, rdata_a}, 32'h0);
    checkOutput("rst_rvalid_b", {31'd0, rvalid_b}, 32'h0);
    checkOutput("rst_sel_err",  {31'd0, sel_err}, 32'h0);
    checkOutput("rst_wcount",   {28'd0, wcount}, 32'h0);
    checkAll("rst");

    // Single write to entry 3.
    applyStimulus(1'b0, 1'b1, 8'h08, 8'hA5, 3'd5, 3'd6);
    tick();
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 3'd3, 3'd2);
    checkOutput("wr3_rdata_a",  {24'd0, rdata_a}, 32'hA5);
    checkOutput("wr3_rvalid_a", {31'd0, rvalid_a}, 32'h1);
    checkOutput("wr3_wcount",   {28'd0, wcount}, 32'h1);
    checkOutput("wr2_rvalid_b", {31'd0, rvalid_b}, 32'h0);
    checkAll("wr3");

    // Multi-hot select is rejected and the error flag sticks.
    applyStimulus(1'b0, 1'b1, 8'h0C, 8'hFF, 3'd2, 3'd3);
    tick();
    applyStimulus(1'b0, 1'b0, 8'h0C, 8'hFF, 3'd2, 3'd3);
    checkOutput("multi_e2",     {24'd0, rdata_a}, 32'h00);
    checkOutput("multi_e3",     {24'd0, rdata_b}, 32'hA5);
    checkOutput("multi_err",    {31'd0, sel_err}, 32'h1);
    checkOutput("multi_wcount", {28'd0, wcount}, 32'h1);
    applyStimulus(1'b0, 1'b1, 8'h02, 8'h5A, 3'd1, 3'd3);
    tick();
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 3'd1, 3'd3);
    checkOutput("sticky_err",   {31'd0, sel_err}, 32'h1);
    checkAll("sticky");

    // Same-cycle read and write of entry 0.
    applyStimulus(1'b0, 1'b1, 8'h01, 8'h11, 3'd0, 3'd0);
    tick();
    applyStimulus(1'b0, 1'b1, 8'h01, 8'h3C, 3'd0, 3'd0);
`ifdef REGFILE_BYPASS_EN
    checkOutput("same_cycle_a", {24'd0, rdata_a}, 32'h3C);
`else
    checkOutput("same_cycle_a", {24'd0, rdata_a}, 32'h11);
`endif
    checkAll("same_cycle");
    tick();
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 3'd0);
    checkOutput("after_edge_a", {24'd0, rdata_a}, 32'h3C);

    // Twenty writes saturate the counter.
    applyStimulus(1'b1, 1'b0, 8'h00, 8'h00, 3'd0, 3'd0);
    tick();
    for (int i = 0; i < 20; i++) begin
      last_data[i % 8] = 8'(i * 13 + 7);
      applyStimulus(1'b0, 1'b1, 8'(1 << (i % 8)), 8'(i * 13 + 7), 3'(i % 8), 3'd0);
      tick();
    end
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 3'd0);
    checkOutput("sat_wcount", {28'd0, wcount}, 32'hF);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 3'(i), 3'(7 - i));
      checkOutput("sat_data",  {24'd0, rdata_a}, {24'd0, last_data[i]});
      checkOutput("sat_valid", {31'd0, rvalid_a}, 32'h1);
    end

    // Reset wins over a simultaneous write.
    applyStimulus(1'b1, 1'b1, 8'h10, 8'hEE, 3'd4, 3'd4);
    tick();
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 3'd4, 3'd4);
    checkOutput("rstwr_e4",     {24'd0, rdata_a}, 32'h0);
    checkOutput("rstwr_valid",  {31'd0, rvalid_a}, 32'h0);
    checkOutput("rstwr_wcount", {28'd0, wcount}, 32'h0);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 9))
        7:       rsel = 8'h00;
        8, 9:    rsel = 8'($urandom);
        default: rsel = 8'(1 << $urandom_range(0, 7));
      endcase
      rrst = ($urandom_range(0, 39) == 0);
      applyStimulus(rrst, 1'($urandom), rsel, 8'($urandom),
                    3'($urandom), 3'($urandom));
      if (!rrst) begin
        checkAll("rand");
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
